// File: rtl/click_pkg.sv
// click_pkg: shared defaults and a clog2 helper for the click pipeline bridges
package click_pkg;
    localparam int DEFAULT_DW = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
endpackage

// File: rtl/click_sync.sv
// click_sync: N-flop synchronizer with synchronous reset
module click_sync #(
    parameter int N = click_pkg::DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [N-1:0] chain;
    always_ff @(posedge clk)
        if (rst) chain <= '0;
        else chain <= {chain[N-2:0], d};
    assign q = chain[N-1];
endmodule

// File: rtl/click_sink.sv
// click_sink: 2-phase bundled-data request to synchronous valid/ready FIFO stream
module click_sink
    import click_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int DEPTH = 4,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   in_reqR,
    input  logic [DW-1:0]          in_data,
    output logic                   out_ackR,
    output logic                   o_valid,
    output logic [DW-1:0]          o_data,
    input  logic                   i_ready,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    logic reqS, ackQ, pending, push, pop;
    logic [AW-1:0] wrPtr, rdPtr;
    logic [DW-1:0] mem [DEPTH];
    click_sync #(.N(SYNC_STAGES)) uSync (.clk(i_clk), .rst(i_rst), .d(in_reqR), .q(reqS));
    assign pending = reqS ^ ackQ;
    assign pop = o_valid & i_ready;
    // a pop on the same edge frees a slot, so a full FIFO can still accept
    assign push = pending & (~o_full | pop);
    assign o_valid = o_count != '0;
    assign o_full = o_count == CW'(DEPTH);
    assign o_data = o_valid ? mem[rdPtr] : '0;
    assign out_ackR = ackQ;
    always_ff @(posedge i_clk)
        if (push) mem[wrPtr] <= in_data;
    always_ff @(posedge i_clk)
        if (i_rst) begin
            ackQ <= 1'b0;
            wrPtr <= '0;
            rdPtr <= '0;
            o_count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
                ackQ <= ~ackQ;
            end
            if (pop) rdPtr <= rdPtr + 1'b1;
            o_count <= o_count + CW'(push) - CW'(pop);
        end
endmodule

// File: tb/tb_click_sink.sv
// tb_click_sink: scoreboard bench for click_sink with an upstream 2-phase model
module tb_click_sink;
    logic i_clk = 0, i_rst = 1, in_reqR = 0, out_ackR, o_valid, i_ready = 0, o_full;
    logic [7:0] in_data = 0, o_data;
    logic [2:0] o_count;
    int nChecks = 0, nPass = 0;
    logic [7:0] expQ[$];

    click_sink dut (
        .i_clk(i_clk), .i_rst(i_rst), .in_reqR(in_reqR), .in_data(in_data),
        .out_ackR(out_ackR), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
        .o_full(o_full), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sendToken(input logic [7:0] d);
        int n;
        n = 0;
        while (in_reqR != out_ackR && n < 200) begin
            tick();
            n++;
        end
        check("ackWait", in_reqR == out_ackR, 1);
        in_data = d;
        in_reqR = ~in_reqR;
        expQ.push_back(d);
    endtask

    always @(negedge i_clk)
        if (!i_rst) begin
            check("countMax", o_count <= 3'd4, 1);
            if (o_valid && i_ready) begin
                if (expQ.size() == 0) check("sbUnderflow", o_data, 32'hFFFF_FFFF);
                else check("popData", o_data, expQ.pop_front());
            end
        end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit sendDone;
        int n;
        // reset sanity while upstream toggles
        for (int i = 0; i < 3; i++) begin
            in_reqR = ~in_reqR;
            @(negedge i_clk);
            check("rstAck", out_ackR, 0);
            check("rstValid", o_valid, 0);
            check("rstCount", o_count, 0);
            check("rstData", o_data, 0);
            tick();
        end
        in_reqR = 0;
        repeat (3) tick();
        i_rst = 0;
        tick();

        // single token latency
        sendToken(8'hA5);
        tick();
        tick();
        @(negedge i_clk);
        check("e1Ack", out_ackR, 0);
        check("e1Valid", o_valid, 0);
        tick();
        @(negedge i_clk);
        check("e2Ack", out_ackR, 1);
        check("e2Valid", o_valid, 1);
        check("e2Data", o_data, 8'hA5);
        check("e2Count", o_count, 1);
        tick();
        i_ready = 1;
        tick();
        i_ready = 0;
        @(negedge i_clk);
        check("drainValid", o_valid, 0);
        tick();

        // fill and stall
        for (int i = 1; i <= 5; i++) sendToken(8'(i));
        repeat (6) tick();
        @(negedge i_clk);
        check("fullFlag", o_full, 1);
        check("fullCount", o_count, 4);
        check("stallAck", out_ackR, !in_reqR);
        tick();
        i_ready = 1;
        tick();
        i_ready = 0;
        @(negedge i_clk);
        check("passAck", out_ackR, in_reqR);
        check("passCount", o_count, 4);
        check("passData", o_data, 2);
        check("passFull", o_full, 1);
        tick();
        i_ready = 1;
        n = 0;
        while (o_valid && n < 20) begin
            tick();
            n++;
        end
        i_ready = 0;
        check("fillDrained", o_valid, 0);
        check("fillSbEmpty", expQ.size(), 0);

        // wrap-around stream with random backpressure
        sendDone = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) sendToken(8'(i));
                sendDone = 1;
            end
            begin
                for (int c = 0; c < 600 && !(sendDone && expQ.size() == 0); c++) begin
                    i_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                i_ready = 0;
            end
        join
        check("wrapSbEmpty", expQ.size(), 0);
        check("wrapCount", o_count, 0);
        tick();

        // reset mid-stream
        sendToken(8'h11);
        sendToken(8'h22);
        sendToken(8'h33);
        n = 0;
        while (in_reqR != out_ackR && n < 50) begin
            tick();
            n++;
        end
        check("midCount", o_count, 3);
        sendToken(8'h44);
        tick();
        i_rst = 1;
        in_reqR = 0;
        expQ.delete();
        tick();
        @(negedge i_clk);
        check("midRstCount", o_count, 0);
        check("midRstAck", out_ackR, 0);
        check("midRstValid", o_valid, 0);
        tick();
        i_rst = 0;
        tick();
        sendToken(8'h3C);
        repeat (4) tick();
        @(negedge i_clk);
        check("postAck", out_ackR, 1);
        check("postCount", o_count, 1);
        check("postData", o_data, 8'h3C);
        tick();
        sendToken(8'hC3);
        repeat (4) tick();
        @(negedge i_clk);
        check("post2Ack", out_ackR, 0);
        check("post2Count", o_count, 2);
        tick();
        i_ready = 1;
        repeat (3) tick();
        i_ready = 0;
        check("postSbEmpty", expQ.size(), 0);
        check("postValid", o_valid, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
